meas_hex_framer: RTL
====================

# meas_hex_framer

Converts each 40-bit TDC measurement into a printable ASCII line: upper-case hex digits, MSB first, then CR LF. It emits the line one byte at a time over a valid/ready byte stream. The block sits between the TDC measurement output (or the rate-limited measurement buffer) and a byte-oriented UART transmitter, so a terminal can read the results directly. It holds one pending measurement while a line is in flight and counts measurements it overwrites.

## Interface
- DATA_W, 40: measurement width. Must be a multiple of 4, range 4..64. Digit count D = DATA_W/4.
- EOL_CRLF, 1: 1 ends each line with 0x0D 0x0A. 0 ends each line with 0x0A only.

- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- meas_in  in  DATA_W  measurement value; sampled when meas_valid=1.
- meas_valid  in  1  single-cycle strobe; always accepted, no ready signal.
- byte_out  out  8  current ASCII byte.
- byte_valid  out  1  byte_out is valid.
- byte_ready  in  1  sink accepts byte_out. A handshake occurs when byte_valid & byte_ready.
- busy  out  1  high while a line is being emitted or a measurement is pending.
- drop_count  out  8  count of overwritten pending measurements; saturates at 255; cleared only by rst.

## Operation
- Reset values: byte_out=0x00, byte_valid=0, busy=0, drop_count=0. State=IDLE, pending empty.
- States:
  - IDLE: no line in progress.
  - DIGIT: emitting hex digits, index 0..D-1.
  - CR: emitting 0x0D.
  - LF: emitting 0x0A.
- Nibble to ASCII conversion:
  - n=0..9 gives 0x30+n.
  - n=10..15 gives 0x41+(n-10).
- Digit order: digit k is nibble meas[DATA_W-1-4k : DATA_W-4-4k].
- Transitions:
  - IDLE, meas_valid=1: load shift register from meas_in, go to DIGIT with k=0.
  - DIGIT, handshake, k<D-1: k+1.
  - DIGIT, handshake, k=D-1: go to CR if EOL_CRLF=1, else LF.
  - CR, handshake: go to LF.
  - LF, handshake: go to the next-line rule below.
- Next-line rule, evaluated at the LF handshake cycle:
  - meas_valid=1 in that cycle: load meas_in and go to DIGIT with k=0. If pending was full, also drop_count+1 and clear pending.
  - Else if pending is full: load pending, clear it, go to DIGIT with k=0.
  - Else: go to IDLE.
- meas_valid while not in IDLE, outside the LF-handshake case:
  - Pending empty: store meas_in, pending=1.
  - Pending full: overwrite with meas_in (latest wins), drop_count+1 (saturating).
- byte_valid is 1 in every state except IDLE.
- While byte_valid=1 and byte_ready=0, byte_out and state are frozen.
- busy = (state != IDLE) | pending.

## Timing
- Latency: meas_valid in IDLE at cycle N gives byte_valid=1 with digit 0 at cycle N+1.
- With byte_ready held at 1, one byte is emitted per cycle. A line is D+2 cycles (D+1 when EOL_CRLF=0).
- No bubble between back-to-back lines: LF handshake at cycle M gives digit 0 of the next line at M+1.
- After LF is accepted with nothing queued, byte_valid=0 at M+1.
- All outputs are registered; byte_out has no combinational path from meas_in or byte_ready.
- rst asserted mid-line: outputs go to reset values immediately, and the in-flight line and pending entry are discarded. The first meas_valid after release starts a fresh line at digit 0.

## Test plan
- Basic line, byte_ready=1: meas_in=0x001234ABCD in IDLE at cycle N. Expect bytes 30 30 31 32 33 34 41 42 43 44 0D 0A on cycles N+1..N+12, byte_valid=0 at N+13, busy=0.
- Backpressure: same input, byte_ready=0 for 5 cycles while digit 3 ('2', 0x32) is presented. Expect byte_out=0x32 stable throughout, no byte lost or duplicated, all 12 bytes delivered.
- Overwrite: during a line, meas_valid with 0x1111111111 then 0x2222222222. Expect drop_count=1, and the next line is "2222222222" CR LF starting the cycle after the LF handshake.
- Simultaneous event: pending=0x3333333333 and meas_valid=0x4444444444 in the LF handshake cycle. Expect the next line "4444444444", drop_count+1, pending empty, busy=0 after that line.
- Edge values and EOL: meas_in=0xFFFFFFFFFF gives "FFFFFFFFFF". With EOL_CRLF=0, meas_in=0 gives 30 x10 then 0A, 11 bytes.
- Saturation and reset: 300 overwrites give drop_count=255. rst mid-line gives byte_valid=0 and drop_count=0 immediately; after release, the next measurement's line starts at digit 0.

Source files
------------

// File: rtl/meas_hex_framer.sv
// Streams each DATA_W-bit measurement as an upper-case hex ASCII line ended by CR LF (or LF),
// one byte per valid/ready handshake, with a one-deep pending slot and a saturating overwrite counter.
module meas_hex_framer #(
  parameter int DATA_W   = 40,
  parameter bit EOL_CRLF = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] meas_in,
  input  logic              meas_valid,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              busy,
  output logic [7:0]        drop_count
);

  localparam int D = DATA_W / 4;
  localparam int IDX_W = (D > 1) ? $clog2(D) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(D - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIGIT = 2'd1,
    CR    = 2'd2,
    LF    = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_nxt;
  logic [DATA_W-1:0] pend_data;
  logic [DATA_W-1:0] pend_data_nxt;
  logic              pend_full;
  logic              pend_full_nxt;
  logic [7:0]        drop_nxt;
  logic [7:0]        byte_nxt;
  logic              valid_nxt;
  logic              busy_nxt;
  logic              hs;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    if (c == 8'hFF) return c;
    else            return c + 8'd1;
  endfunction

  // byte_valid mirrors (state != IDLE), so it doubles as the handshake qualifier
  assign hs = byte_valid & byte_ready;

  // State register and control outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      pend_full  <= 1'b0;
      drop_count <= 8'd0;
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      pend_full  <= pend_full_nxt;
      drop_count <= drop_nxt;
      byte_out   <= byte_nxt;
      byte_valid <= valid_nxt;
      busy       <= busy_nxt;
    end
  end

  // Data-only registers; their contents are qualified by state/pend_full
  always_ff @(posedge clk) begin
    shreg     <= shreg_nxt;
    pend_data <= pend_data_nxt;
  end

  // Next-state: line sequencing, pending slot and drop accounting
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    shreg_nxt     = shreg;
    pend_data_nxt = pend_data;
    pend_full_nxt = pend_full;
    drop_nxt      = drop_count;

    unique case (state)
      IDLE: begin
        if (meas_valid) begin
          state_nxt = DIGIT;
          idx_nxt   = '0;
          shreg_nxt = meas_in;
        end
      end
      DIGIT: begin
        if (hs) begin
          if (idx == LAST_IDX) begin
            state_nxt = EOL_CRLF ? CR : LF;
          end else begin
            idx_nxt   = idx + 1'b1;
            shreg_nxt = shreg << 4;
          end
        end
      end
      CR: begin
        if (hs) state_nxt = LF;
      end
      LF: begin
        if (hs) begin
          // A fresh measurement in the same cycle wins over the queued one
          if (meas_valid) begin
            state_nxt = DIGIT;
            idx_nxt   = '0;
            shreg_nxt = meas_in;
            if (pend_full) begin
              pend_full_nxt = 1'b0;
              drop_nxt      = sat_inc(drop_count);
            end
          end else if (pend_full) begin
            state_nxt     = DIGIT;
            idx_nxt       = '0;
            shreg_nxt     = pend_data;
            pend_full_nxt = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (state != IDLE && !(state == LF && hs) && meas_valid) begin
      pend_data_nxt = meas_in;
      pend_full_nxt = 1'b1;
      if (pend_full) drop_nxt = sat_inc(drop_count);
    end
  end

  // Output decode from the next state so the byte lands registered with its state
  always_comb begin
    byte_nxt = 8'h00;
    unique case (state_nxt)
      DIGIT:   byte_nxt = hex_ascii(shreg_nxt[DATA_W-1 -: 4]);
      CR:      byte_nxt = 8'h0D;
      LF:      byte_nxt = 8'h0A;
      default: byte_nxt = 8'h00;
    endcase
    valid_nxt = (state_nxt != IDLE);
    busy_nxt  = (state_nxt != IDLE) | pend_full_nxt;
  end

endmodule
